// File: rtl/mdu.sv
// Iterative multiply/divide unit holding the HI/LO pair.
// One shift-add or restoring-divide step per clock, then a sign fix-up cycle.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic                 r_is_div;
  logic                 r_bz;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_b;
  // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   r_acc;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_msum;
  logic [WIDTH:0]       w_dshift;
  logic [WIDTH:0]       w_ddiff;
  logic                 w_dge;
  logic [2*WIDTH-1:0]   w_prod_neg;
  logic [WIDTH-1:0]     w_quo_neg;
  logic [WIDTH-1:0]     w_rem_neg;
  logic [CW-1:0]        w_cnt_dec;

  assign w_abs_a    = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_abs_b    = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
  assign w_dshift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_b};
  // Shifted remainder is below 2*divisor, so the top bit of the difference is its sign.
  assign w_dge      = ~w_ddiff[WIDTH];
  assign w_prod_neg = ~r_acc + 1'b1;
  assign w_quo_neg  = ~r_acc[WIDTH-1:0] + 1'b1;
  assign w_rem_neg  = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
  assign w_cnt_dec  = r_cnt - 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_is_div <= 1'b0;
      r_bz     <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= op[0] & a[WIDTH-1];
            r_dbz    <= 1'b0;
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
            r_is_div <= op[1];
            r_b      <= w_abs_b;
            if (op[1] && (b == '0)) begin
              r_bz    <= 1'b1;
              r_acc   <= {{WIDTH{1'b0}}, a};
              r_state <= S_FIX;
            end else begin
              r_bz    <= 1'b0;
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_state <= op[1] ? S_DIV : S_MUL;
            end
          end else begin
            if (mthi) r_hi <= wd;
            if (mtlo) r_lo <= wd;
          end
        end
        S_MUL: begin
          r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          r_cnt <= w_cnt_dec;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= {(w_dge ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_dge};
          r_cnt <= w_cnt_dec;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_bz) begin
            r_hi  <= r_acc[WIDTH-1:0];
            r_lo  <= {WIDTH{1'b1}};
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= r_sign_q ? w_quo_neg : r_acc[WIDTH-1:0];
            r_hi <= r_sign_r ? w_rem_neg : r_acc[2*WIDTH-1:WIDTH];
          end else begin
            {r_hi, r_lo} <= r_sign_q ? w_prod_neg : r_acc;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a behavioural model pushes expected HI/LO at start,
// each scenario task pops and compares when done is seen.
module tb_mdu;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  res_t sb[$];
  res_t got_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mdu #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic [63:0] p;
    longint sx, sy, q, rm;
    r.dbz = 1'b0;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'd0: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == 2'd2) begin
          r.lo = x / y; r.hi = x % y;
        end else begin
          q = sx / sy; rm = sx % sy;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Drives one start, pushes the model result, and waits (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int edges, output int busy_cyc, output logic dbz_e0);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clock); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    busy_cyc = busy ? 1 : 0;
    dbz_e0 = div_by_zero;
    edges = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (done) begin edges = n; break; end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    n_tests++;
    if ({hi, lo, busy, done, div_by_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b dbz=%b want all 0",
               hi, lo, busy, done, div_by_zero);
    end
  endtask

  task automatic test_multu;
    int e, bc; logic d0;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, d0);
    n_tests++;
    if (e !== 33) begin n_fail++; $display("FAIL multu_latency got %0d want 33", e); end
    n_tests++;
    if (bc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    got_exp = sb.pop_front();
    n_tests++;
    if ({hi, lo} !== {got_exp.hi, got_exp.lo} || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo);
    end
    @(posedge clock); #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done); end
    last_hi = got_exp.hi; last_lo = got_exp.lo;
  endtask

  task automatic test_mult;
    int e, bc; logic d0;
    logic [1:0]  ops[3] = '{2'd1, 2'd1, 2'd1};
    logic [31:0] as[3]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs[3]  = '{32'd7, 32'h8000_0000, 32'hFEDC_BA98};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], e, bc, d0);
      got_exp = sb.pop_front();
      n_tests++;
      if (e !== 33 || hi !== got_exp.hi || lo !== got_exp.lo) begin
        n_fail++;
        $display("FAIL mult_%0d got edges=%0d %h_%h want 33 %h_%h", i, e, hi, lo, got_exp.hi, got_exp.lo);
      end
      last_hi = got_exp.hi; last_lo = got_exp.lo;
    end
  endtask

  task automatic test_div;
    int e, bc; logic d0;
    logic [1:0]  ops[5] = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs[5]  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], e, bc, d0);
      got_exp = sb.pop_front();
      n_tests++;
      if (e !== 33 || hi !== got_exp.hi || lo !== got_exp.lo || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL div_%0d got edges=%0d hi=%h lo=%h dbz=%b want 33 hi=%h lo=%h dbz=0",
                 i, e, hi, lo, div_by_zero, got_exp.hi, got_exp.lo);
      end
      last_hi = got_exp.hi; last_lo = got_exp.lo;
    end
  endtask

  task automatic test_div_by_zero;
    int e, bc; logic d0;
    run_op(2'd2, 32'd5, 32'd0, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (e !== 1 || bc !== 1) begin
      n_fail++; $display("FAIL dbz_timing got edges=%0d busy=%0d want 1 1", e, bc);
    end
    n_tests++;
    if (hi !== got_exp.hi || lo !== got_exp.lo || div_by_zero !== got_exp.dbz) begin
      n_fail++;
      $display("FAIL dbz_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
               hi, lo, div_by_zero, got_exp.hi, got_exp.lo, got_exp.dbz);
    end
    run_op(2'd0, 32'd6, 32'd9, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (d0 !== 1'b0 || div_by_zero !== 1'b0 || lo !== got_exp.lo || hi !== got_exp.hi) begin
      n_fail++;
      $display("FAIL dbz_clear got dbz_e0=%b dbz=%b lo=%h want 0 0 %h", d0, div_by_zero, lo, got_exp.lo);
    end
    last_hi = got_exp.hi; last_lo = got_exp.lo;
  endtask

  task automatic test_ignore_busy;
    int e; logic hold_ok;
    hold_ok = 1'b1;
    op = 2'd1; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    sb.push_back(model(2'd1, 32'hFFFF_FFFD, 32'd7));
    @(posedge clock); #1;
    start = 1'b0;
    e = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 10) begin
        start = 1'b1; op = 2'd2; a = 32'd1; b = 32'd0; mthi = 1'b1; wd = 32'h1234;
      end
      if (n == 11) begin start = 1'b0; mthi = 1'b0; end
      @(posedge clock); #1;
      if (done) begin e = n; break; end
      if (hi !== last_hi || lo !== last_lo) hold_ok = 1'b0;
    end
    got_exp = sb.pop_front();
    n_tests++;
    if (!hold_ok) begin n_fail++; $display("FAIL hilo_hold got changed mid-op want %h_%h", last_hi, last_lo); end
    n_tests++;
    if (e !== 33 || hi !== got_exp.hi || lo !== got_exp.lo || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy got edges=%0d %h_%h dbz=%b want 33 %h_%h 0",
               e, hi, lo, div_by_zero, got_exp.hi, got_exp.lo);
    end
    last_hi = got_exp.hi; last_lo = got_exp.lo;
  endtask

  task automatic test_mt;
    int e, bc; logic d0;
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h0000_ABCD;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    n_tests++;
    if (hi !== 32'h0000_ABCD || lo !== 32'h0000_ABCD) begin
      n_fail++; $display("FAIL mthi_mtlo got %h_%h want 0000abcd_0000abcd", hi, lo);
    end
    mtlo = 1'b1; wd = 32'h5555_0000;
    @(posedge clock); #1;
    mtlo = 1'b0;
    n_tests++;
    if (hi !== 32'h0000_ABCD || lo !== 32'h5555_0000) begin
      n_fail++; $display("FAIL mtlo_only got %h_%h want 0000abcd_55550000", hi, lo);
    end
    mthi = 1'b1; wd = 32'h7777_7777;
    run_op(2'd0, 32'd3, 32'd4, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (hi !== got_exp.hi || lo !== got_exp.lo) begin
      n_fail++; $display("FAIL start_beats_mthi got %h_%h want %h_%h", hi, lo, got_exp.hi, got_exp.lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h0000_ABCD;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    last_hi = 32'h0000_ABCD; last_lo = 32'h0000_ABCD;
  endtask

  task automatic test_async_reset;
    int e, bc; logic d0;
    op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n < 15; n++) begin @(posedge clock); #1; end
    n_tests++;
    if (busy !== 1'b1 || hi !== last_hi || lo !== last_lo) begin
      n_fail++; $display("FAIL pre_reset got busy=%b %h_%h want 1 %h_%h", busy, hi, lo, last_hi, last_lo);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({hi, lo, busy, done, div_by_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
    end
    #3 reset = 1'b1;
    @(posedge clock); #1;
    run_op(2'd2, 32'd9, 32'd3, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (e !== 33 || hi !== got_exp.hi || lo !== got_exp.lo) begin
      n_fail++; $display("FAIL after_reset got edges=%0d %h_%h want 33 %h_%h", e, hi, lo, got_exp.hi, got_exp.lo);
    end
  endtask

  task automatic test_back_to_back;
    int e, bc; logic d0;
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (e !== 33 || hi !== got_exp.hi || lo !== got_exp.lo) begin
      n_fail++; $display("FAIL b2b_first got edges=%0d %h_%h want 33 %h_%h", e, hi, lo, got_exp.hi, got_exp.lo);
    end
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, d0);
    got_exp = sb.pop_front();
    n_tests++;
    if (e !== 33 || bc !== 33 || hi !== got_exp.hi || lo !== got_exp.lo) begin
      n_fail++;
      $display("FAIL b2b_second got edges=%0d busy=%0d %h_%h want 33 33 %h_%h",
               e, bc, hi, lo, got_exp.hi, got_exp.lo);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wd = '0;
    last_hi = '0; last_lo = '0;
    #12;
    test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_busy();
    test_mt();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
